// File: rtl/filt_sel_ctrl.sv
// Filter-select controller: arbitrates two requesters, then fades, switches and settles the LPF bank.
// Define FILT_SEL_CTRL_FADE_EN to enable the gain fade-out/fade-in around the switch.
module filt_sel_ctrl #(
  parameter int unsigned GAIN_STEP      = 8,
  parameter int unsigned SETTLE_SAMPLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_en,
  input  logic [1:0] req,
  input  logic [2:0] sel0,
  input  logic [2:0] sel1,
  output logic [1:0] ack,
  output logic [2:0] filt_sel,
  output logic [7:0] gain,
  output logic       busy
);

  typedef enum logic [2:0] {StIdle, StFadeOut, StSwitch, StSettle, StFadeIn} state_e;

  localparam logic [7:0] Unity      = 8'd128;
  localparam logic [7:0] Step       = 8'(GAIN_STEP);
  localparam logic [7:0] SettleLast = 8'(SETTLE_SAMPLES - 1);

`ifdef FILT_SEL_CTRL_FADE_EN
  localparam state_e AfterGrant  = StFadeOut;
  localparam state_e AfterSettle = StFadeIn;
`else
  // Fade states become unreachable, so gain never leaves unity.
  localparam state_e AfterGrant  = StSwitch;
  localparam state_e AfterSettle = StIdle;
`endif

  state_e     state;
  logic [2:0] pending;
  logic [7:0] settle_cnt;
  logic       prio;        // requester favoured when both ask at once
  logic       win;
  logic       win_valid;
  logic [2:0] win_sel;

  always_comb begin
    win_valid = |req;
    win       = 1'b0;
    case (req)
      2'b10:   win = 1'b1;
      2'b11:   win = prio;
      default: win = 1'b0;
    endcase
  end

  assign win_sel = win ? sel1 : sel0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      filt_sel   <= 3'd0;
      gain       <= Unity;
      busy       <= 1'b0;
      ack        <= 2'b00;
      pending    <= 3'd0;
      prio       <= 1'b0;
      settle_cnt <= 8'd0;
    end else begin
      ack <= 2'b00;
      case (state)
        StIdle: begin
          // Skip the clk the ack is visible so a still-held req is not granted twice.
          if (win_valid && (ack == 2'b00)) begin
            ack     <= win ? 2'b10 : 2'b01;
            prio    <= ~win;
            pending <= win_sel;
            if (win_sel != filt_sel) begin
              state <= AfterGrant;
              busy  <= 1'b1;
            end
          end
        end
        StFadeOut: begin
          if (sample_en) begin
            if (gain <= Step) begin
              gain  <= 8'd0;
              state <= StSwitch;
            end else begin
              gain <= gain - Step;
            end
          end
        end
        StSwitch: begin
          if (sample_en) begin
            filt_sel   <= pending;
            settle_cnt <= 8'd0;
            state      <= StSettle;
          end
        end
        StSettle: begin
          if (sample_en) begin
            if (settle_cnt == SettleLast) begin
              state <= AfterSettle;
              busy  <= (AfterSettle != StIdle);
            end else begin
              settle_cnt <= settle_cnt + 8'd1;
            end
          end
        end
        StFadeIn: begin
          if (sample_en) begin
            if (gain >= (Unity - Step)) begin
              gain  <= Unity;
              state <= StIdle;
              busy  <= 1'b0;
            end else begin
              gain <= gain + Step;
            end
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/filt_sel_ctrl.md
FILT_SEL_CTRL -- requirements
Module: filt_sel_ctrl

Interface
REQ-001 Parameter: GAIN_STEP, default 8, gain change per sample strobe during a fade; SHALL be a power of two from 1 to 128.
REQ-002 Parameter: SETTLE_SAMPLES, default 16, sample strobes to wait after a select change; legal range 1..255.
REQ-003 Port: clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: sample_en  input  1  one-clk strobe, one per audio sample.
REQ-006 Port: req  input  2  per-requester change request, level, held until ack.
REQ-007 Port: sel0 / sel1  input  3 each  requested filter select for requester 0 / 1.
REQ-008 Port: ack  output  2  one-clk grant pulse per requester.
REQ-009 Port: filt_sel  output  3  filter select driven to the LPF bank.
REQ-010 Port: gain  output  8  output gain for downstream multiplier; 128 = unity, 0 = mute.
REQ-011 Port: busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 States: IDLE, FADE_OUT, SWITCH, SETTLE, FADE_IN; registered one-hot or binary, with outputs registered.
REQ-013 IDLE arbitration is evaluated every clk: a single active req wins; when both are active, round-robin applies, granting the requester not granted last.
REQ-014 Grant SHALL capture the winner's sel into a pending register, pulse that ack bit for exactly 1 clk, and update the round-robin pointer.
REQ-015 Grant with sel equal to current filt_sel SHALL ack and remain in IDLE (no-op; pointer still updates).
REQ-016 Grant with a different sel SHALL move IDLE->FADE_OUT on the same edge as the ack.
REQ-017 All state advances after grant occur only on clocks with sample_en=1.
REQ-018 FADE_OUT: each sample_en, gain -= GAIN_STEP, saturating at 0; on the strobe where gain reaches 0, go to SWITCH.
REQ-019 SWITCH: on the next sample_en, filt_sel <= pending, clear the settle counter, and go to SETTLE.
REQ-020 SETTLE: count sample_en; after SETTLE_SAMPLES strobes, go to FADE_IN; gain holds 0.
REQ-021 FADE_IN: each sample_en, gain += GAIN_STEP, saturating at 128; on the strobe where gain reaches 128, go to IDLE.
REQ-022 While busy, req is ignored: no ack is issued and nothing is queued; a requester still asserting req is arbitrated on the first IDLE clk.
REQ-023 A req deasserted before ack SHALL be dropped with no side effects.
REQ-024 ack is never asserted for both bits in the same clk.
REQ-025 sample_en arriving on the same clk as the grant SHALL NOT advance FADE_OUT; the first fade step is on the next strobe.
REQ-026 Default-parameter change latency: 16 + 1 + 16 + 16 = 49 sample strobes from grant to IDLE.

Reset
REQ-027 Reset, including assertion mid-sequence, SHALL immediately force: state=IDLE, filt_sel=3'b000, gain=128, busy=0, ack=2'b00, pending=0, round-robin pointer favoring requester 0, settle counter=0.
REQ-028 On the first clk after reset deassertion, a pending req is arbitrated normally.

Configuration
REQ-029 Macro FILT_SEL_CTRL_FADE_EN defined: full sequence IDLE->FADE_OUT->SWITCH->SETTLE->FADE_IN->IDLE as above.
REQ-030 FILT_SEL_CTRL_FADE_EN undefined: FADE_OUT and FADE_IN are omitted; grant goes IDLE->SWITCH->SETTLE->IDLE; gain is constant 128; default latency is 17 sample strobes.

Verification
REQ-031 After reset, req=01, sel0=3 (fade build) -> ack=01 one clk; gain steps 120,112,...,0 over 16 strobes; filt_sel=3 on the 17th strobe; gain returns to 128 at strobe 49; busy low after.
REQ-032 req=11 held in IDLE -> ack=01 first; after that sequence completes, ack=10 is issued next; a second simultaneous pair yields ack=01 again.
REQ-033 req=01 with sel0 equal to filt_sel -> ack=01 in 1 clk, busy stays 0, gain stays 128.
REQ-034 req=10 asserted during SETTLE -> no ack until IDLE, then ack=10 on the first IDLE clk.
REQ-035 reset pulsed at FADE_OUT with gain=64 -> same clk: gain=128, filt_sel=0, busy=0, state IDLE.
REQ-036 Build without FILT_SEL_CTRL_FADE_EN, req=01 sel0=5 -> gain is always 128; filt_sel=5 on strobe 1; busy low after strobe 17.
